// File: rtl/find_first_one_idx_pkg.sv
// Shared helpers for the find-first-one priority encoder.
//   clog2()       : ceiling log2, constant-evaluable for parameter math.
//   index_width() : width of the encoded index, never less than one bit.
package find_first_one_idx_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int index_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/find_first_one_idx_tree.sv
// Combinational log-depth encoder for the lowest set bit.
//   vector_in  : bits to scan, bit 0 has the highest priority
//   found_out  : at least one bit of vector_in is set
//   idx_out    : index of the lowest set bit, 0 when nothing is set
// The input is zero-padded to a power of two. Level 0 holds one leaf per bit.
// Each level above merges pairs of nodes, and the lower-index half wins.
module first_one_tree_encoder
  import find_first_one_idx_pkg::*;
#(
  parameter int VECTOR_LENGTH = 8,
  parameter int INDEX_WIDTH   = index_width(VECTOR_LENGTH)
) (
  input  logic [VECTOR_LENGTH-1:0] vector_in,
  output logic                     found_out,
  output logic [INDEX_WIDTH-1:0]   idx_out
);

  localparam int LEVELS = clog2(VECTOR_LENGTH);
  localparam int PADDED = 1 << LEVELS;

  logic [PADDED-1:0] pad;

  always_comb begin
    pad                    = '0;
    pad[VECTOR_LENGTH-1:0] = vector_in;
  end

  for (genvar l = 0; l <= LEVELS; l++) begin : lvl
    logic [(PADDED>>l)-1:0]                  f;
    logic [(PADDED>>l)-1:0][INDEX_WIDTH-1:0] ix;

    if (l == 0) begin : g_leaf
      assign f  = pad;
      assign ix = '0;
    end else begin : g_node
      for (genvar j = 0; j < (PADDED >> l); j++) begin : g_pair
        logic f_lo, f_hi;
        assign f_lo  = lvl[l-1].f[2*j];
        assign f_hi  = lvl[l-1].f[2*j+1];
        assign f[j]  = f_lo | f_hi;
        // Gate the upper-half select bit with f_hi so that an empty subtree
        // keeps index 0.
        assign ix[j] = f_lo ? lvl[l-1].ix[2*j]
                     : (f_hi ? (lvl[l-1].ix[2*j+1] | (INDEX_WIDTH'(1) << (l-1)))
                             : '0);
      end
    end
  end

  assign found_out = lvl[LEVELS].f[0];
  assign idx_out   = lvl[LEVELS].ix[0];

endmodule

// File: rtl/find_first_one_idx.sv
// Registered priority encoder for the lowest set bit. Latency is one cycle,
// and it takes one input every cycle.
//   clk_in              : clock
//   reset_in            : synchronous active-high reset, clears both outputs
//   vector_in           : vector to scan, bit 0 has the highest priority
//   first_one_index_out : index of the lowest set bit, zero-extended
//   one_is_found_out    : vector_in had at least one bit set
module find_first_one_idx
  import find_first_one_idx_pkg::*;
#(
  parameter int VECTOR_LENGTH    = 8,
  parameter int MAX_OUTPUT_WIDTH = 32
) (
  input  logic                        clk_in,
  input  logic                        reset_in,
  input  logic [VECTOR_LENGTH-1:0]    vector_in,
  output logic [MAX_OUTPUT_WIDTH-1:0] first_one_index_out,
  output logic                        one_is_found_out
);

  localparam int INDEX_WIDTH = index_width(VECTOR_LENGTH);

  logic                   found_d, found_q;
  logic [INDEX_WIDTH-1:0] idx_d, idx_q;

  first_one_tree_encoder #(
    .VECTOR_LENGTH (VECTOR_LENGTH),
    .INDEX_WIDTH   (INDEX_WIDTH)
  ) u_tree (
    .vector_in (vector_in),
    .found_out (found_d),
    .idx_out   (idx_d)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      idx_q   <= '0;
      found_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      found_q <= found_d;
    end
  end

  // Only the encoded bits are registered. The wide bus is zero-filled here.
  always_comb begin
    first_one_index_out                  = '0;
    first_one_index_out[INDEX_WIDTH-1:0] = idx_q;
  end

  assign one_is_found_out = found_q;

endmodule

// File: tb/tb_find_first_one_idx.sv
module tb_find_first_one_idx;

  localparam int OW = 32;

  logic clk = 1'b0;
  logic rst;
  logic [7:0]  v8;
  logic [0:0]  v1;
  logic [4:0]  v5;
  logic [32:0] v33;
  logic [OW-1:0] i8, i1, i5, i33;
  logic f8, f1, f5, f33;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  find_first_one_idx #(.VECTOR_LENGTH(8),  .MAX_OUTPUT_WIDTH(OW)) dut8 (
    .clk_in(clk), .reset_in(rst), .vector_in(v8),
    .first_one_index_out(i8), .one_is_found_out(f8));
  find_first_one_idx #(.VECTOR_LENGTH(1),  .MAX_OUTPUT_WIDTH(OW)) dut1 (
    .clk_in(clk), .reset_in(rst), .vector_in(v1),
    .first_one_index_out(i1), .one_is_found_out(f1));
  find_first_one_idx #(.VECTOR_LENGTH(5),  .MAX_OUTPUT_WIDTH(OW)) dut5 (
    .clk_in(clk), .reset_in(rst), .vector_in(v5),
    .first_one_index_out(i5), .one_is_found_out(f5));
  find_first_one_idx #(.VECTOR_LENGTH(33), .MAX_OUTPUT_WIDTH(OW)) dut33 (
    .clk_in(clk), .reset_in(rst), .vector_in(v33),
    .first_one_index_out(i33), .one_is_found_out(f33));

  // Reference model: linear scan for the lowest set bit within n bits.
  function automatic logic [OW-1:0] ref_idx(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++)
      if (v[i]) return OW'(i);
    return '0;
  endfunction

  function automatic logic ref_found(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++)
      if (v[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; v8 = 8'hFF; v1 = 1'b1; v5 = 5'h1F; v33 = '1;
    step();
    tests++;
    if (i8 !== 0 || f8 !== 1'b0) begin
      fails++; $display("FAIL reset8: idx=%0d found=%b want idx=0 found=0", i8, f8);
    end
    tests++;
    if (i33 !== 0 || f33 !== 1'b0) begin
      fails++; $display("FAIL reset33: idx=%0d found=%b want idx=0 found=0", i33, f33);
    end
    rst = 1'b0;
    step();
    tests++;
    if (i8 !== 0 || f8 !== 1'b1) begin
      fails++; $display("FAIL release8: idx=%0d found=%b want idx=0 found=1", i8, f8);
    end
    // A reset in mid-stream discards the value in flight.
    v8 = 8'h10;
    step();
    rst = 1'b1; v8 = 8'h08;
    step();
    tests++;
    if (i8 !== 0 || f8 !== 1'b0) begin
      fails++; $display("FAIL midreset: idx=%0d found=%b want idx=0 found=0", i8, f8);
    end
    rst = 1'b0;
    step();
    tests++;
    if (i8 !== 3 || f8 !== 1'b1) begin
      fails++; $display("FAIL post_midreset: idx=%0d found=%b want idx=3 found=1", i8, f8);
    end
  endtask

  task automatic test_zero();
    v8 = 8'h00;
    step();
    tests++;
    if (i8 !== 0 || f8 !== 1'b0) begin
      fails++; $display("FAIL zero: idx=%0d found=%b want idx=0 found=0", i8, f8);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [5];
    seq = '{8'h01, 8'h10, 8'h80, 8'hA4, 8'hFE};
    v8 = seq[0];
    for (int k = 0; k < 5; k++) begin
      step();
      if (k < 4) v8 = seq[k+1];
      tests++;
      if (i8 !== ref_idx(64'(seq[k]), 8) || f8 !== 1'b1) begin
        fails++;
        $display("FAIL b2b[%0d]: in=%h idx=%0d found=%b want idx=%0d found=1",
                 k, seq[k], i8, f8, ref_idx(64'(seq[k]), 8));
      end
    end
  endtask

  task automatic test_multi();
    v8 = 8'h80;
    step();
    tests++;
    if (i8 !== 7 || f8 !== 1'b1) begin
      fails++; $display("FAIL multi80: idx=%0d found=%b want idx=7 found=1", i8, f8);
    end
    v8 = 8'hC0;
    step();
    tests++;
    if (i8 !== 6 || f8 !== 1'b1) begin
      fails++; $display("FAIL multiC0: idx=%0d found=%b want idx=6 found=1", i8, f8);
    end
  endtask

  task automatic test_sweep8();
    for (int k = 0; k < 256; k++) begin
      v8 = 8'(k);
      step();
      tests++;
      if (i8 !== ref_idx(64'(k), 8) || f8 !== ref_found(64'(k), 8)) begin
        fails++;
        $display("FAIL sweep8: in=%h idx=%0d found=%b want idx=%0d found=%b",
                 k[7:0], i8, f8, ref_idx(64'(k), 8), ref_found(64'(k), 8));
      end
    end
  endtask

  task automatic test_sweep1();
    for (int k = 0; k < 4; k++) begin
      v1 = 1'(k);
      step();
      tests++;
      if (i1 !== 0 || f1 !== ref_found(64'(k & 1), 1)) begin
        fails++;
        $display("FAIL sweep1: in=%b idx=%0d found=%b want idx=0 found=%b",
                 v1, i1, f1, ref_found(64'(k & 1), 1));
      end
    end
  endtask

  task automatic test_sweep5();
    for (int k = 0; k < 32; k++) begin
      v5 = 5'(k);
      step();
      tests++;
      if (i5 !== ref_idx(64'(k), 5) || f5 !== ref_found(64'(k), 5)) begin
        fails++;
        $display("FAIL sweep5: in=%h idx=%0d found=%b want idx=%0d found=%b",
                 k[4:0], i5, f5, ref_idx(64'(k), 5), ref_found(64'(k), 5));
      end
    end
  endtask

  task automatic test_sweep33();
    logic [32:0] pat;
    // Single bit walk, bit 32 included, then random vectors masked from a
    // random position upward so that every lowest-bit index is reached.
    for (int k = 0; k < 33 + 300; k++) begin
      if (k < 33) pat = 33'(1) << k;
      else        pat = {$urandom, $urandom} & ({33{1'b1}} << $urandom_range(0, 33));
      v33 = pat;
      step();
      tests++;
      if (i33 !== ref_idx(64'(pat), 33) || f33 !== ref_found(64'(pat), 33)) begin
        fails++;
        $display("FAIL sweep33: in=%h idx=%0d found=%b want idx=%0d found=%b",
                 pat, i33, f33, ref_idx(64'(pat), 33), ref_found(64'(pat), 33));
      end
    end
    v33 = 33'h1_0000_0000;
    step();
    tests++;
    if (i33 !== 32'd32 || f33 !== 1'b1 || i33[31:6] !== 26'd0) begin
      fails++; $display("FAIL bit32: idx=%h found=%b want idx=20 found=1", i33, f33);
    end
  endtask

  task automatic test_random8();
    logic [7:0] pat;
    for (int k = 0; k < 200; k++) begin
      pat = 8'($urandom);
      v8 = pat;
      step();
      tests++;
      if (i8 !== ref_idx(64'(pat), 8) || f8 !== ref_found(64'(pat), 8)) begin
        fails++;
        $display("FAIL random8: in=%h idx=%0d found=%b want idx=%0d found=%b",
                 pat, i8, f8, ref_idx(64'(pat), 8), ref_found(64'(pat), 8));
      end
    end
  endtask

  initial begin
    rst = 1'b1; v8 = '0; v1 = '0; v5 = '0; v33 = '0;
    #1;
    test_reset();
    test_zero();
    test_back_to_back();
    test_multi();
    test_sweep8();
    test_sweep1();
    test_sweep5();
    test_sweep33();
    test_random8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/find_first_one_idx.md
Name: find_first_one_idx

Overview:
Registered priority encoder. Scans an input bit vector from bit 0 upward and reports the index of the lowest-numbered set bit, plus a found flag. Used wherever a free slot, request or valid entry must be picked with lowest-index priority, e.g. arbiters, free-list allocation and cache way selection. Output is zero-extended to a fixed, wide index bus.

Parameters:
- VECTOR_LENGTH, 8: width of the scanned vector. Must be >= 1.
- MAX_OUTPUT_WIDTH, 32: width of the index output bus. Must be >= max(1, clog2(VECTOR_LENGTH)).

Ports:
- clk_in, input, 1: clock; all state updates on the rising edge.
- reset_in, input, 1: synchronous, active-high reset.
- vector_in, input, VECTOR_LENGTH: vector to scan. Bit 0 has the highest priority.
- first_one_index_out, output, MAX_OUTPUT_WIDTH: index of the lowest set bit of vector_in, zero-extended.
- one_is_found_out, output, 1: 1 when vector_in had at least one bit set.

Behaviour:
- Combinational core: idx = smallest i with vector_in[i]==1; found = |vector_in.
- No bit set: idx = 0 and found = 0. The index value 0 is meaningful only together with found.
- Outputs are registered, latency 1 cycle. Outputs sampled after rising edge N reflect vector_in as sampled at edge N.
- No handshake; a new vector may be presented every cycle, giving throughput 1/cycle.
- Reset: at a rising edge with reset_in==1, first_one_index_out <= 0 and one_is_found_out <= 0, regardless of vector_in. Reset dominates the data path.
- Reset mid-operation: the value in flight is discarded. The first valid result appears one edge after reset_in deasserts.
- Width rule: the encoded index occupies the low clog2(VECTOR_LENGTH) bits (at least 1 bit). Upper bits of first_one_index_out are always 0.
- Multiple bits set: only the lowest index is reported. Higher bits are ignored entirely.
- VECTOR_LENGTH==1: index is always 0; found = vector_in[0].
- Non-power-of-two VECTOR_LENGTH (e.g. 5, 12): pad internally with zeros up to the next power of two. Padding must never produce found=1 or an out-of-range index.
- Encoder structure: log-depth binary tree.
  - Leaves are 1-bit (found, idx) pairs.
  - Each node merges the left (lower-index) and right halves: found = fL | fR; idx = fL ? {0, idxL} : {1, idxR}.
  - This keeps timing scalable to VECTOR_LENGTH = 64..512.
- No X propagation: with a known vector_in, both outputs must be fully known after the first clock edge following reset.

Decomposition:
- Shared package: a clog2 constant function, plus a localparam INDEX_WIDTH = max(1, clog2(VECTOR_LENGTH)) derived from it.
- Sub-module: first_one_tree_encoder. Purely combinational; parameterised on VECTOR_LENGTH; outputs found and INDEX_WIDTH-bit idx; built recursively or with generate levels.
- Top level: instantiates the tree, zero-extends idx to MAX_OUTPUT_WIDTH, and holds the output registers with synchronous reset.

Test Plan:
- Assert reset_in for one cycle, vector_in=8'hFF -> first_one_index_out=0, one_is_found_out=0 after that edge. Release reset -> index=0, found=1 one edge later.
- vector_in=8'h00 -> after one edge index=0, found=0.
- vector_in=8'h01 -> index=0, found=1. Next cycle vector_in=8'h10 -> index=4, found=1. Next cycle vector_in=8'h80 -> index=7, found=1. Results arrive back-to-back, each exactly one edge after its input.
- Multiple ones: vector_in=8'hA4 -> index=2. vector_in=8'hFE -> index=1. vector_in=8'h80 then 8'hC0 -> index 7 then 6.
- Exhaustive sweep of all 256 values for VECTOR_LENGTH=8, compared against a lowest-set-bit reference model.
- Rerun the sweep with VECTOR_LENGTH=1, 5 and 33. For VECTOR_LENGTH=33 with only bit 32 set -> index=32, found=1, bits [31:6] of the output = 0.
